// File: rtl/click_pkg.sv
// Shared definitions for the click burst generator: channel states,
// LFSR constants and the small helpers used to derive per-channel jitter.
package click_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Each channel sees the shared LFSR rotated right by ROT_STEP*k bits.
  localparam int ROT_STEP = 3;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Rotate a 16-bit word right by s positions (s taken modulo 16).
  function automatic logic [15:0] rotr16(input logic [15:0] v, input int s);
    int sh;
    sh = s % 16;
    return (v >> sh) | (v << (16 - sh));
  endfunction

endpackage

// File: rtl/click_channel.sv
// One click channel: IDLE -> WAIT (off-gap) -> ON (click) state machine
// with a single down-counter shared by the gap and the on-time.
module click_channel
  import click_pkg::*;
#(
  parameter int LEVEL_W     = 4,
  parameter int CNT_W       = 32,
  parameter int BASE_PERIOD = 240000,
  parameter int ON_SHIFT    = 20,
  parameter int JITTER_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [LEVEL_W-1:0]  level,
  input  logic                mode,
  input  logic                trigger,
  input  logic                jitter_en,
  input  logic [JITTER_W-1:0] jitter,
  output logic                click,
  output logic                strobe,
  output logic                busy
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LEVEL_W-1:0] level_lat;
  logic [CNT_W-1:0]   gap;
  logic [CNT_W-1:0]   on_len;

  // Gap length for the next WAIT and on-time for the next ON, from the
  // level captured when WAIT was entered (a level change during WAIT
  // therefore does not alter the click that follows it).
  always_comb begin
    gap    = CNT_W'(BASE_PERIOD) + (jitter_en ? CNT_W'(jitter) : '0);
    on_len = CNT_W'(((CNT_W'(1) << LEVEL_W) - CNT_W'(level_lat)) << ON_SHIFT);
  end

  // Channel FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      level_lat <= '0;
      click     <= 1'b0;
      strobe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (level != '0) && (!mode || trigger)) begin
            state     <= ST_WAIT;
            cnt       <= gap;
            level_lat <= level;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt <= CNT_W'(1)) begin
            state  <= ST_ON;
            cnt    <= on_len;
            click  <= 1'b1;
            strobe <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (!enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
            click <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt <= CNT_W'(1)) begin
            click <= 1'b0;
            if (!mode && (level != '0)) begin
              state     <= ST_WAIT;
              cnt       <= gap;
              level_lat <= level;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          click  <= 1'b0;
          strobe <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/click_burst_gen.sv
// Multi-channel click burst generator: shared jitter LFSR, level unpacking
// and one click_channel instance per output.
module click_burst_gen
  import click_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int LEVEL_W     = 4,
  parameter int CNT_W       = 32,
  parameter int BASE_PERIOD = 240000,
  parameter int ON_SHIFT    = 20,
  parameter int JITTER_W    = 8
) (
  input  logic                        i_clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         i_enable,
  input  logic [CHANNELS*LEVEL_W-1:0] i_level,
  input  logic                        i_mode,
  input  logic [CHANNELS-1:0]         i_trigger,
  input  logic                        i_jitter_en,
  output logic [CHANNELS-1:0]         o_click,
  output logic [CHANNELS-1:0]         o_strobe,
  output logic [CHANNELS-1:0]         o_busy
);

  localparam logic [63:0] GAP_MAX = 64'(BASE_PERIOD) + (64'd1 << JITTER_W);
  localparam logic [63:0] ON_MAX  = (64'd1 << LEVEL_W) << ON_SHIFT;
  localparam logic [63:0] CNT_LIM = 64'd1 << CNT_W;

  logic [15:0] lfsr;

  // Shared LFSR: seeded on reset, free-running otherwise.
  always_ff @(posedge i_clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  // Simulation guard: the longest gap and on-time must fit the counters.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      assert ((GAP_MAX < CNT_LIM) && (ON_MAX < CNT_LIM))
        else $error("click_burst_gen: counter width too small for gap/on-time");
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [JITTER_W-1:0] jit;
    assign jit = JITTER_W'(rotr16(lfsr, ROT_STEP * k));

    click_channel #(
      .LEVEL_W    (LEVEL_W),
      .CNT_W      (CNT_W),
      .BASE_PERIOD(BASE_PERIOD),
      .ON_SHIFT   (ON_SHIFT),
      .JITTER_W   (JITTER_W)
    ) u_ch (
      .clk      (i_clk),
      .reset    (reset),
      .enable   (i_enable[k]),
      .level    (i_level[k*LEVEL_W +: LEVEL_W]),
      .mode     (i_mode),
      .trigger  (i_trigger[k]),
      .jitter_en(i_jitter_en),
      .jitter   (jit),
      .click    (o_click[k]),
      .strobe   (o_strobe[k]),
      .busy     (o_busy[k])
    );
  end

endmodule

// File: tb/tb_click_burst_gen.sv
// Self-checking bench for click_burst_gen with a timeline-based reference
// model: each active channel is described by the absolute cycle numbers at
// which its click starts and ends.
module tb_click_burst_gen;

  localparam int CH = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] i_enable;
  logic [CH*LW-1:0] i_level;
  logic          i_mode;
  logic [CH-1:0] i_trigger;
  logic          i_jitter_en;
  logic [CH-1:0] o_click, o_strobe, o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  click_burst_gen #(
    .CHANNELS(4), .LEVEL_W(4), .CNT_W(32), .BASE_PERIOD(10), .ON_SHIFT(2), .JITTER_W(8)
  ) dut (
    .i_clk(clk), .reset(reset), .i_enable(i_enable), .i_level(i_level),
    .i_mode(i_mode), .i_trigger(i_trigger), .i_jitter_en(i_jitter_en),
    .o_click(o_click), .o_strobe(o_strobe), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] rot_right(input logic [15:0] v, input int s);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < s; i++) r = {r[0], r[15:1]};
    return r;
  endfunction

  int          ecount = 0;
  logic [15:0] m_lfsr = 16'h0;
  bit          m_busy [CH];
  int          m_start[CH];
  int          m_end  [CH];
  logic [CH-1:0] exp_click = '0, exp_strobe = '0, exp_busy = '0;
  int          gap_len;
  logic [3:0]  lv;

  task automatic model_begin(input int k, input logic [3:0] l);
    gap_len    = 10 + (i_jitter_en ? int'(rot_right(m_lfsr, 3 * k) & 16'h00FF) : 0);
    m_busy[k]  = 1'b1;
    m_start[k] = ecount + gap_len;
    m_end[k]   = m_start[k] + (16 - int'(l)) * 4;
  endtask

  always @(posedge clk) begin
    ecount++;
    for (int k = 0; k < CH; k++) begin
      lv = i_level[k*LW +: LW];
      if (reset) m_busy[k] = 1'b0;
      else if (m_busy[k] && !i_enable[k]) m_busy[k] = 1'b0;
      else if (!m_busy[k]) begin
        if (i_enable[k] && lv != 0 && (!i_mode || i_trigger[k])) model_begin(k, lv);
      end else if (ecount == m_end[k]) begin
        if (!i_mode && lv != 0) model_begin(k, lv);
        else m_busy[k] = 1'b0;
      end
      exp_busy[k]   = m_busy[k];
      exp_click[k]  = m_busy[k] && ecount >= m_start[k] && ecount < m_end[k];
      exp_strobe[k] = m_busy[k] && ecount == m_start[k];
    end
    if (reset) m_lfsr = 16'hACE1;
    else       m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  // Every cycle, away from the active edge, compare all outputs.
  always @(negedge clk) begin
    if (ecount > 0) begin
      check("click",  32'(o_click),  32'(exp_click));
      check("strobe", 32'(o_strobe), 32'(exp_strobe));
      check("busy",   32'(o_busy),   32'(exp_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_level(input int k, input logic [3:0] l);
    i_level[k*LW +: LW] = l;
  endtask

  task automatic wait_click0(input string tag);
    int t;
    t = 0;
    while (!o_click[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(o_click[0]), 32'd1);
  endtask

  initial begin
    reset = 1'b1; i_enable = '0; i_level = '0; i_mode = 1'b0;
    i_trigger = '0; i_jitter_en = 1'b0;
    cycles(3);
    check("reset_outputs", {o_click, o_strobe, o_busy}, 32'd0);
    check("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
    reset = 1'b0;

    // 1: continuous, ch0 level 15
    set_level(0, 4'd15); i_enable = 4'b0001;
    cycles(60);

    // 2: ch1 level 8 and ch2 level 14 together
    i_enable = '0; cycles(2);
    set_level(1, 4'd8); set_level(2, 4'd14); i_enable = 4'b0110;
    cycles(120);

    // 3: single-shot with a repeated trigger while busy
    i_enable = '0; cycles(2);
    i_mode = 1'b1; i_enable = 4'b0001;
    i_trigger = 4'b0001; cycles(1); i_trigger = '0;
    cycles(5);
    i_trigger = 4'b0001; cycles(1); i_trigger = '0;
    cycles(30);
    check("single_shot_idle", 32'(o_busy[0]), 32'd0);

    // 4: jitter on, continuous, all channels level 15
    i_mode = 1'b0; i_jitter_en = 1'b1;
    for (int k = 0; k < CH; k++) set_level(k, 4'd15);
    i_enable = 4'b1111;
    cycles(1500);

    // 5a: enable dropped mid-ON
    i_jitter_en = 1'b0; i_enable = '0; cycles(2);
    i_enable = 4'b0001;
    wait_click0("wait_click_a");
    i_enable = '0;
    cycles(1);
    check("drop_click", 32'(o_click[0]), 32'd0);

    // 5b: reset mid-ON
    set_level(0, 4'd1); i_enable = 4'b0001; cycles(1);
    wait_click0("wait_click_b");
    cycles(3);
    reset = 1'b1;
    cycles(1);
    check("rst_click", 32'(o_click), 32'd0);
    check("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    reset = 1'b0;

    // 6: level 15 -> 0 during WAIT
    i_enable = '0; cycles(2);
    set_level(0, 4'd15); i_enable = 4'b0001;
    cycles(3);
    check("in_wait", 32'({o_busy[0], o_click[0]}), 32'b10);
    set_level(0, 4'd0);
    cycles(40);
    check("lvl0_idle", 32'(o_busy[0]), 32'd0);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) i_enable[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) set_level($urandom_range(0, 3), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) i_mode = ~i_mode;
      if ($urandom_range(0, 79) == 0) i_jitter_en = ~i_jitter_en;
      i_trigger = 4'($urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 499) == 0);
      cycles(1);
      if (reset) check("rand_rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    end
    reset = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
